// File: rtl/tlut_prod_gen.sv
// Temporal-unary outer-product generator: W[p] gates a shared time counter,
// and V is accumulated into row p for the first W[p] cycles, giving prod[p][q] = W[p]*V[q].
module tlut_prod_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int DIM_ROW1   = 3,
    parameter int DIM_COL1   = 3,
    parameter int DIM_ROW2   = 3,
    parameter int DIM_COL2   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic [DIM_ROW2*DIM_COL2-1:0][DATA_WIDTH-1:0] op_w,
    input  logic [DIM_ROW1*DIM_COL1-1:0][DATA_WIDTH-1:0] op_v,
    output logic [DIM_ROW2*DIM_COL2-1:0][DIM_ROW1*DIM_COL1-1:0][ACC_WIDTH-1:0] prod,
    output logic out_valid,
    input  logic out_ready,
    output logic busy,
    output logic [1:0] fsm_state
);
    localparam int NW = DIM_ROW2 * DIM_COL2;
    localparam int NV = DIM_ROW1 * DIM_COL1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready/valid outputs here depend on registered state only.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [DATA_WIDTH-1:0] cnt, len, w_max;
    logic [NW-1:0][DATA_WIDTH-1:0] w_q;
    logic [NV-1:0][DATA_WIDTH-1:0] v_q;
    logic [NW-1:0] row_en;

    always_comb begin
        w_max = '0;
        for (int p = 0; p < NW; p++) begin
            if (op_w[p] > w_max) w_max = op_w[p];
        end
    end

    // One comparator per row, shared by every column of that row.
    always_comb begin
        row_en = '0;
        for (int p = 0; p < NW; p++) row_en[p] = (cnt < w_q[p]);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = (w_max == '0) ? DONE : RUN;
            RUN:  if (cnt == len - DATA_WIDTH'(1)) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign fsm_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt     <= '0;
            len     <= '0;
            w_q     <= '0;
            v_q     <= '0;
            prod    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        w_q  <= op_w;
                        v_q  <= op_v;
                        prod <= '0;
                        cnt  <= '0;
                        len  <= w_max;
                    end
                end
                RUN: begin
                    for (int p = 0; p < NW; p++) begin
                        if (row_en[p]) begin
                            for (int q = 0; q < NV; q++) begin
                                prod[p][q] <= prod[p][q] + ACC_WIDTH'(v_q[q]);
                            end
                        end
                    end
                    cnt <= cnt + DATA_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tlut_prod_gen.sv
// Directed bench for tlut_prod_gen: latency, busy span, products, backpressure and mid-run reset.
module tb_tlut_prod_gen;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int NW = 9;
    localparam int NV = 9;

    logic clk = 1'b0;
    logic rst, in_valid, out_ready;
    logic in_ready, out_valid, busy;
    logic [1:0] fsm_state;
    logic [NW-1:0][DW-1:0] op_w;
    logic [NV-1:0][DW-1:0] op_v;
    logic [NW-1:0][NV-1:0][AW-1:0] prod;

    logic [NW-1:0][DW-1:0] w_vec;
    logic [NV-1:0][DW-1:0] v_vec;
    logic [AW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    tlut_prod_gen dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_w(op_w), .op_v(op_v), .prod(prod), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int w[9], input int v[9]);
        for (int i = 0; i < 9; i++) begin
            w_vec[i] = DW'(w[i]);
            v_vec[i] = DW'(v[i]);
        end
    endtask

    task automatic start_op(input string tag);
        check({tag, " in_ready before accept"}, AW'(in_ready), 1);
        op_w = w_vec;
        op_v = v_vec;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op_w = '0;
        op_v = '0;
    endtask

    task automatic wait_done(input string tag, input int exp_len);
        int cycles;
        int busy_cnt;
        cycles = 0;
        busy_cnt = busy ? 1 : 0;
        while (!out_valid && cycles < 300) begin
            tick();
            cycles++;
            if (busy) busy_cnt++;
        end
        check({tag, " latency"}, AW'(cycles), AW'(exp_len));
        check({tag, " busy cycles"}, AW'(busy_cnt), AW'(exp_len));
    endtask

    task automatic check_prod(input string tag);
        for (int p = 0; p < NW; p++)
            for (int q = 0; q < NV; q++)
                exp_q.push_back(AW'(w_vec[p]) * AW'(v_vec[q]));
        for (int p = 0; p < NW; p++)
            for (int q = 0; q < NV; q++)
                check($sformatf("%s prod[%0d][%0d]", tag, p, q), prod[p][q], exp_q.pop_front());
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " in_ready after out handshake"}, AW'(in_ready), 1);
        check({tag, " out_valid after out handshake"}, AW'(out_valid), 0);
    endtask

    int id_w[9]    = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int seq_v[9]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int mix_w[9]   = '{3, 0, 7, 1, 2, 5, 0, 4, 6};
    int two_v[9]   = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
    int max_v[9]   = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
    int zero_w[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    int mixv_v[9]  = '{9, 8, 7, 6, 5, 4, 3, 2, 1};

    initial begin
        logic [NW-1:0][NV-1:0][AW-1:0] held;
        logic stable;
        logic [AW-1:0] m;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_w = '0; op_v = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset in_ready", AW'(in_ready), 1);
        check("reset out_valid", AW'(out_valid), 0);
        check("reset busy", AW'(busy), 0);
        check("reset state", AW'(fsm_state), 0);
        check("reset prod[0][0]", prod[0][0], 0);
        check("reset prod[8][8]", prod[8][8], 0);

        // Identity W
        set_ops(id_w, seq_v);
        start_op("ident");
        wait_done("ident", 1);
        check("ident prod[4][3]", prod[4][3], 4);
        check("ident prod[1][3]", prod[1][3], 0);
        check_prod("ident");
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                m = '0;
                for (int k = 0; k < 3; k++) m = m + prod[i*3+k][k*3+j];
                check($sformatf("ident mult[%0d][%0d]", i, j), m, AW'(i*3 + j + 1));
            end
        release_out("ident");

        // Mixed values, then backpressure with a competing in_valid
        set_ops(mix_w, two_v);
        start_op("mixed");
        wait_done("mixed", 7);
        check("mixed prod[2][0]", prod[2][0], 14);
        check("mixed prod[6][5]", prod[6][5], 0);
        check("mixed prod[5][4]", prod[5][4], 10);
        check_prod("mixed");
        held = prod;
        stable = 1'b1;
        op_w = '1;
        op_v = '1;
        for (int i = 0; i < 20; i++) begin
            in_valid = (i >= 10);
            tick();
            if (prod !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        check("backpressure stable", AW'(stable), 1);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("bp both high -> idle", AW'(fsm_state), 0);
        check("bp in_ready", AW'(in_ready), 1);
        check("bp prod held in idle", AW'(prod === held), 1);
        tick();
        check("bp in_valid not taken in done", AW'(busy), 0);

        // Extremes
        set_ops(max_v, max_v);
        start_op("max");
        wait_done("max", 255);
        check("max prod[8][8]", prod[8][8], 65025);
        check_prod("max");
        release_out("max");

        // Zero W
        set_ops(zero_w, mixv_v);
        start_op("zero");
        wait_done("zero", 0);
        check_prod("zero");
        release_out("zero");

        // Reset mid-RUN at cnt=3
        set_ops(mix_w, two_v);
        start_op("rst");
        tick();
        tick();
        tick();
        check("rst busy before pulse", AW'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst state", AW'(fsm_state), 0);
        check("rst in_ready", AW'(in_ready), 1);
        check("rst out_valid", AW'(out_valid), 0);
        check("rst busy", AW'(busy), 0);
        stable = 1'b1;
        for (int p = 0; p < NW; p++)
            for (int q = 0; q < NV; q++)
                if (prod[p][q] !== '0) stable = 1'b0;
        check("rst prod cleared", AW'(stable), 1);

        set_ops(id_w, seq_v);
        start_op("post-rst ident");
        wait_done("post-rst ident", 1);
        check_prod("post-rst ident");
        release_out("post-rst ident");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
